seq_detect_display: RTL and testbench

SEQ_DETECT_DISPLAY -- requirements
Module: seq_detect_display

---
 rtl/seq_detect_display.sv | 146 ++++++++++++++
 tb/tb_seq_detect_display.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_display.sv
// Serial pattern detector with a BCD match counter shown on a multiplexed seven-segment display.
// Optional build macro: LEAD_ZERO_BLANK_EN blanks leading zero digits above the most significant nonzero digit.
`timescale 1ns/1ps
module seq_detect_display #(
    parameter int PAT_W    = 4,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int OVERLAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              load,
    output logic              match,
    output logic [3:0]        leds,
    output logic [6:0]        seven_seg,
    output logic [DIGITS-1:0] seven_enable
);
    localparam int CNT_W  = 4 * DIGITS;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PAT_W-1:0]  r_shift;
    logic [PAT_W-1:0]  r_pat;
    logic [3:0]        r_fill;
    logic [CNT_W-1:0]  r_count;
    logic              r_match;
    logic [SCAN_W-1:0] r_scan;
    logic [DIG_W-1:0]  r_digit;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_en;

    logic [PAT_W-1:0]  w_shift_next;
    logic [3:0]        w_fill_next;
    logic              w_hit;
    logic [CNT_W-1:0]  w_count_inc;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_carry;
    logic              w_scan_wrap;
    logic [DIG_W-1:0]  w_digit_next;
    logic [3:0]        w_digit_val;
    logic              w_blank;
    logic [6:0]        w_seg_next;
    logic [DIGITS-1:0] w_en_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // A strobe that coincides with load is dropped, so it can never produce a match.
    assign w_shift_next = {r_shift[PAT_W-2:0], bit_in};
    assign w_fill_next  = (r_fill == 4'(PAT_W)) ? r_fill : r_fill + 4'd1;
    assign w_hit        = bit_valid && !load && (w_fill_next == 4'(PAT_W)) && (w_shift_next == r_pat);

    always_comb begin
        w_count_inc = r_count;
        w_carry     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_carry) begin
                if (r_count[4*k +: 4] == 4'd9) begin
                    w_count_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    assign w_count_next = w_hit ? w_count_inc : r_count;
    assign w_scan_wrap  = (r_scan == SCAN_W'(SCAN_DIV - 1));
    assign w_digit_next = !w_scan_wrap ? r_digit :
                          (r_digit == DIG_W'(DIGITS - 1)) ? '0 : r_digit + 1'b1;

    // Display registers are loaded from next-state values so segments and enables change together.
    always_comb begin
        w_digit_val = 4'd0;
        w_blank     = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_digit_next == DIG_W'(k)) w_digit_val = w_count_next[4*k +: 4];
        end
`ifdef LEAD_ZERO_BLANK_EN
        for (int k = 1; k < DIGITS; k++) begin
            if ((w_digit_next == DIG_W'(k)) && ((w_count_next >> (4*k)) == '0)) w_blank = 1'b1;
        end
`endif
    end

    assign w_seg_next = w_blank ? 7'b1111111 : seg_decode(w_digit_val);
    assign w_en_next  = ~(DIGITS'(1) << w_digit_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_pat   <= '0;
            r_fill  <= 4'd0;
            r_count <= '0;
            r_match <= 1'b0;
            r_scan  <= '0;
            r_digit <= '0;
            r_seg   <= 7'b1000000;
            r_en    <= ~DIGITS'(1);
        end else begin
            r_match <= w_hit;
            r_count <= w_count_next;
            if (load) begin
                r_pat   <= pattern;
                r_shift <= '0;
                r_fill  <= 4'd0;
            end else if (bit_valid) begin
                r_shift <= w_shift_next;
                r_fill  <= ((OVERLAP == 0) && w_hit) ? 4'd0 : w_fill_next;
            end
            r_scan  <= w_scan_wrap ? '0 : r_scan + 1'b1;
            r_digit <= w_digit_next;
            r_seg   <= w_seg_next;
            r_en    <= w_en_next;
        end
    end

    generate
        if (PAT_W >= 4) begin : g_leds_wide
            assign leds = r_shift[3:0];
        end else begin : g_leds_narrow
            assign leds = {{(4-PAT_W){1'b0}}, r_shift};
        end
    endgenerate

    assign match        = r_match;
    assign seven_seg    = r_seg;
    assign seven_enable = r_en;
endmodule

// File: tb/tb_seq_detect_display.sv
// Directed bench for seq_detect_display: three instances (overlapping, non-overlapping, single digit).
`timescale 1ns/1ps
module tb_seq_detect_display;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b1111000;
`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pattern = 4'b0000;

    logic       match_a, match_b, match_c;
    logic [3:0] leds_a, leds_b, leds_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic [3:0] en_a, en_b;
    logic [0:0] en_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_display #(.PAT_W(4), .DIGITS(4), .SCAN_DIV(4), .OVERLAP(1)) dut_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .pattern(pattern),
        .load(load), .match(match_a), .leds(leds_a), .seven_seg(seg_a), .seven_enable(en_a));
    seq_detect_display #(.PAT_W(4), .DIGITS(4), .SCAN_DIV(4), .OVERLAP(0)) dut_b (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .pattern(pattern),
        .load(load), .match(match_b), .leds(leds_b), .seven_seg(seg_b), .seven_enable(en_b));
    seq_detect_display #(.PAT_W(4), .DIGITS(1), .SCAN_DIV(4), .OVERLAP(0)) dut_c (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .pattern(pattern),
        .load(load), .match(match_c), .leds(leds_c), .seven_seg(seg_c), .seven_enable(en_c));

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: seg_ref = 7'b1000000;
            1: seg_ref = 7'b1111001;
            2: seg_ref = 7'b0100100;
            3: seg_ref = 7'b0110000;
            4: seg_ref = 7'b0011001;
            5: seg_ref = 7'b0010010;
            6: seg_ref = 7'b0000010;
            7: seg_ref = 7'b1111000;
            8: seg_ref = 7'b0000000;
            9: seg_ref = 7'b0010000;
            default: seg_ref = 7'b1111111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_valid = 1'b0; load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] p);
        pattern = p; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b; bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    // Collects one full scan of each display; digits never seen stay X.
    task automatic capture(output logic [27:0] sa, output logic [27:0] sb, output logic [6:0] sc);
        sa = 'x; sb = 'x; sc = 'x;
        for (int c = 0; c < 16; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (en_a == ~(4'b0001 << k)) sa[7*k +: 7] = seg_a;
                if (en_b == ~(4'b0001 << k)) sb[7*k +: 7] = seg_b;
            end
            if (en_c == 1'b0) sc = seg_c;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL reset_match got %b exp 0", match_a); end
        checks++; if (leds_a !== 4'b0000) begin errors++; $display("FAIL reset_leds got %b exp 0000", leds_a); end
        checks++; if (en_a !== 4'b1110) begin errors++; $display("FAIL reset_en got %b exp 1110", en_a); end
        checks++; if (seg_a !== S0) begin errors++; $display("FAIL reset_seg got %b exp %b", seg_a, S0); end
        checks++; if (match_b !== 1'b0) begin errors++; $display("FAIL reset_match_b got %b exp 0", match_b); end
        checks++; if (en_c !== 1'b0) begin errors++; $display("FAIL reset_en_c got %b exp 0", en_c); end
        checks++; if (seg_c !== S0) begin errors++; $display("FAIL reset_seg_c got %b exp %b", seg_c, S0); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) tick();
            exp_en  = ~(4'b0001 << ((i / 4) % 4));
            exp_seg = (((i / 4) % 4) == 0) ? S0 : LZ;
            checks++; if (en_a !== exp_en) begin errors++; $display("FAIL scan_en[%0d] got %b exp %b", i, en_a, exp_en); end
            checks++; if (seg_a !== exp_seg) begin errors++; $display("FAIL scan_seg[%0d] got %b exp %b", i, seg_a, exp_seg); end
        end
    endtask

    task automatic test_basic();
        logic [3:0]  p;
        logic [27:0] sa, sb;
        logic [6:0]  sc;
        p = 4'b1011;
        do_reset();
        do_load(p);
        for (int i = 3; i >= 0; i--) begin
            send_bit(p[i]);
            checks++; if (match_a !== (i == 0)) begin errors++; $display("FAIL basic_match[%0d] got %b exp %b", i, match_a, (i == 0)); end
        end
        checks++; if (leds_a !== 4'b1011) begin errors++; $display("FAIL basic_leds got %b exp 1011", leds_a); end
        tick();
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b exp 0", match_a); end
        capture(sa, sb, sc);
        checks++; if (sa !== {LZ, LZ, LZ, S1}) begin errors++; $display("FAIL basic_count_a got %h exp %h", sa, {LZ, LZ, LZ, S1}); end
        checks++; if (sb !== {LZ, LZ, LZ, S1}) begin errors++; $display("FAIL basic_count_b got %h exp %h", sb, {LZ, LZ, LZ, S1}); end
    endtask

    task automatic test_overlap();
        logic [6:0]  stream;
        logic [27:0] sa, sb;
        logic [6:0]  sc;
        stream = 7'b1011011;
        do_reset();
        do_load(4'b1011);
        for (int j = 0; j < 7; j++) begin
            send_bit(stream[6-j]);
            checks++; if (match_a !== (j == 3 || j == 6)) begin errors++; $display("FAIL ovl_match_a[%0d] got %b exp %b", j, match_a, (j == 3 || j == 6)); end
            checks++; if (match_b !== (j == 3)) begin errors++; $display("FAIL ovl_match_b[%0d] got %b exp %b", j, match_b, (j == 3)); end
        end
        capture(sa, sb, sc);
        checks++; if (sa !== {LZ, LZ, LZ, S2}) begin errors++; $display("FAIL ovl_count_a got %h exp %h", sa, {LZ, LZ, LZ, S2}); end
        checks++; if (sb !== {LZ, LZ, LZ, S1}) begin errors++; $display("FAIL ovl_count_b got %h exp %h", sb, {LZ, LZ, LZ, S1}); end
    endtask

    task automatic test_wrap();
        logic [27:0] sa, sb;
        logic [6:0]  sc;
        do_reset();
        do_load(4'b0011);
        for (int g = 0; g < 10; g++) begin
            for (int j = 0; j < 4; j++) begin
                send_bit(j >= 2);
                checks++; if (match_c !== (j == 3)) begin errors++; $display("FAIL wrap_match[%0d.%0d] got %b exp %b", g, j, match_c, (j == 3)); end
            end
            checks++; if (seg_c !== seg_ref((g + 1) % 10)) begin errors++; $display("FAIL wrap_seg[%0d] got %b exp %b", g, seg_c, seg_ref((g + 1) % 10)); end
        end
        capture(sa, sb, sc);
        checks++; if (sa !== {LZ, LZ, S1, S0}) begin errors++; $display("FAIL wrap_count_a got %h exp %h", sa, {LZ, LZ, S1, S0}); end
        checks++; if (sc !== S0) begin errors++; $display("FAIL wrap_count_c got %b exp %b", sc, S0); end
    endtask

    task automatic test_load_collision();
        logic [3:0] p;
        p = 4'b1011;
        do_reset();
        do_load(p);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        pattern = p; load = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        load = 1'b0; bit_valid = 1'b0;
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL coll_match got %b exp 0", match_a); end
        checks++; if (leds_a !== 4'b0000) begin errors++; $display("FAIL coll_leds got %b exp 0000", leds_a); end
        for (int i = 3; i >= 0; i--) begin
            send_bit(p[i]);
            checks++; if (match_a !== (i == 0)) begin errors++; $display("FAIL coll_match[%0d] got %b exp %b", i, match_a, (i == 0)); end
        end
    endtask

    task automatic test_reset_midcount();
        logic [3:0]  p;
        logic [27:0] sa, sb;
        logic [6:0]  sc;
        p = 4'b1011;
        do_reset();
        do_load(p);
        for (int g = 0; g < 7; g++) begin
            for (int i = 3; i >= 0; i--) send_bit(p[i]);
        end
        capture(sa, sb, sc);
        checks++; if (sa !== {LZ, LZ, LZ, S7}) begin errors++; $display("FAIL mid_count7 got %h exp %h", sa, {LZ, LZ, LZ, S7}); end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        rst = 1'b0; bit_valid = 1'b0;
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL mid_rst_match got %b exp 0", match_a); end
        checks++; if (leds_a !== 4'b0000) begin errors++; $display("FAIL mid_rst_leds got %b exp 0000", leds_a); end
        checks++; if (en_a !== 4'b1110) begin errors++; $display("FAIL mid_rst_en got %b exp 1110", en_a); end
        checks++; if (seg_a !== S0) begin errors++; $display("FAIL mid_rst_seg got %b exp %b", seg_a, S0); end
        capture(sa, sb, sc);
        checks++; if (sa !== {LZ, LZ, LZ, S0}) begin errors++; $display("FAIL mid_count0 got %h exp %h", sa, {LZ, LZ, LZ, S0}); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_basic();
        test_overlap();
        test_wrap();
        test_load_collision();
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
